// File: rtl/mul_seq_if.sv
// mul_seq_if: start/busy handshake, product output and shared-adder operand/sum bus.
interface mul_seq_if #(parameter int WIDTH = 8) ();
  logic               start_i;
  logic [WIDTH-1:0]   a_bi;
  logic [WIDTH-1:0]   b_bi;
  logic               busy_o;
  logic               done_o;
  logic [2*WIDTH-1:0] y_bo;
  logic [2*WIDTH:0]   add_a_bo;
  logic [2*WIDTH:0]   add_b_bo;
  logic [2*WIDTH:0]   add_y_bi;
  modport slave (
    input  start_i, a_bi, b_bi, add_y_bi,
    output busy_o, done_o, y_bo, add_a_bo, add_b_bo
  );
  modport master (
    output start_i, a_bi, b_bi, add_y_bi,
    input  busy_o, done_o, y_bo, add_a_bo, add_b_bo
  );
endinterface

// File: rtl/mul_seq.sv
// mul_seq: unsigned shift-and-add multiplier, one partial product per clock via an external adder.
module mul_seq #(
  parameter int WIDTH = 8
) (
  input logic      clk_i,
  input logic      rst_i,
  mul_seq_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic {IDLE, WORK} state_t;
  state_t          r_state;
  logic [WIDTH-1:0] r_a, r_b;
  logic [PW-1:0]   r_acc, r_y;
  logic [CW-1:0]   r_ctr;
  logic            r_done;
  logic [PW:0]     w_pp;
  logic [PW-1:0]   w_sum;
  logic            w_last;
  logic            w_unused_carry;
  always_comb begin
    w_pp           = r_b[r_ctr] ? ({{(WIDTH + 1){1'b0}}, r_a} << r_ctr) : '0;
    w_sum          = bus.add_y_bi[PW-1:0];
    w_unused_carry = bus.add_y_bi[PW];
    w_last         = r_ctr == CW'(WIDTH - 1);
  end
  assign bus.busy_o   = r_state == WORK;
  assign bus.done_o   = r_done;
  assign bus.y_bo     = r_y;
  assign bus.add_a_bo = (r_state == WORK) ? {1'b0, r_acc} : '0;
  assign bus.add_b_bo = (r_state == WORK) ? w_pp : '0;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_ctr   <= '0;
      r_y     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.start_i) begin
          r_a     <= bus.a_bi;
          r_b     <= bus.b_bi;
          r_acc   <= '0;
          r_ctr   <= '0;
          r_state <= WORK;
        end
      end else begin
        r_acc <= w_sum;
        r_ctr <= r_ctr + 1'b1;
        if (w_last) begin
          r_y     <= w_sum;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
      end
    end
  end
endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
Sequential unsigned shift-and-add multiplier, one partial product per clock. It sits directly upstream of the shared 17-bit `adder` stage. Each cycle it drives the adder's operands with {accumulator, shifted partial product} and consumes the adder's sum as the next accumulator value. Start/busy handshake to the controlling logic; the 16-bit product is held on `y_bo` until the next completion.

Parameters:
- WIDTH, 8, operand width. Product width is 2*WIDTH. Adder port width is 2*WIDTH+1, which is 17 at the default.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- start_i  input  1  start request; sampled only while idle.
- a_bi  input  WIDTH  multiplicand; sampled on the accepting edge.
- b_bi  input  WIDTH  multiplier; sampled on the accepting edge.
- busy_o  output  1  high while a multiplication is in progress.
- done_o  output  1  one-cycle pulse after the result is written.
- y_bo  output  2*WIDTH  product; registered, held between operations.
- add_a_bo  output  2*WIDTH+1  adder operand A (to adder a_bi).
- add_b_bo  output  2*WIDTH+1  adder operand B (to adder b_bi).
- add_y_bi  input  2*WIDTH+1  adder sum (from adder y_bo).

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - state=IDLE; busy_o=0, done_o=0, y_bo=0.
  - Internal accumulator, bit counter and operand registers are cleared.
  - An operation in progress is aborted with no result written.
- States: IDLE and WORK.
- IDLE:
  - busy_o=0; add_a_bo=0, add_b_bo=0.
  - On an edge with start_i=1: latch a_bi→A_r and b_bi→B_r, clear acc and ctr, go to WORK.
- WORK (combinational drive to the adder):
  - add_a_bo = {1'b0, acc}.
  - add_b_bo = B_r[ctr] ? zero-extended (A_r << ctr) : 0.
- WORK (each edge):
  - acc <= add_y_bi[2*WIDTH-1:0]; ctr <= ctr+1.
  - add_y_bi[2*WIDTH] is ignored; it is never set, because the product always fits in 2*WIDTH bits.
- Completion:
  - On the edge where ctr==WIDTH-1: y_bo <= add_y_bi[2*WIDTH-1:0], state → IDLE, done_o <= 1.
- Latency: the accepting edge is E0. Additions happen on edges E1..E_WIDTH. busy_o is high for exactly WIDTH cycles (after E0 through E_WIDTH). y_bo is updated and done_o rises at E_WIDTH; done_o clears on the next edge.
- start_i while busy_o=1 is ignored; a_bi/b_bi changes during WORK have no effect.
- start_i in the cycle where done_o=1 is accepted (state is already IDLE). Back-to-back throughput is one product per WIDTH+1 cycles.
- y_bo is not cleared on start; it keeps the previous product until the new completion edge.
- The adder is purely combinational. The loop add_a_bo→add_y_bi→acc must close within one cycle, so there is no extra pipeline register.
- Operand zero is handled with no special case: the full WIDTH cycles are still spent.

Test Plan:
- Reset, then start_i=1 with a=5, b=3 → busy_o high for 8 cycles; y_bo=15 and done_o=1 pulse at edge E8; add_b_bo=5 at ctr0, 10 at ctr1, 0 at ctr2..7.
- a=255, b=255 → y_bo=65025 (0xFE01); add_y_bi[16] stays 0 throughout.
- a=0, b=200 → busy_o still 8 cycles; y_bo=0; add_b_bo=0 in every cycle.
- Start a=12, b=10; pulse start_i with a=7, b=7 at E3 → request ignored; y_bo=120; no second operation.
- Start a=9, b=9; assert rst_i asynchronously between edges at ctr=4 → busy_o=0, y_bo=0 immediately; next start with a=2, b=3 gives y_bo=6.
- Back-to-back: after a=6, b=7 (y_bo=42), hold start_i=1 in the done_o cycle with a=3, b=4 → accepted; y_bo stays 42 until 8 edges later, then becomes 12.
